decode_pipe_stage: RTL and testbench
====================================

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

Interface
REQ-001 XLEN, 64, datapath width (32 or 64).
REQ-002 WB_BYPASS, 1, enables the writeback-to-decode operand bypass when 1.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_valid  in  1  upstream holds a valid fetched instruction.
REQ-006 o_ready  out  1  stage can accept; equals !o_valid || i_ready.
REQ-007 i_pc  in  XLEN  PC of the instruction.
REQ-008 i_instruction  in  32  raw instruction word.
REQ-009 o_rs1_index / o_rs2_index  out  5 each  combinational i_instruction[19:15] / [24:20] to the register file.
REQ-010 i_rs1_value / i_rs2_value  in  XLEN each  register file read data, same cycle.
REQ-011 i_wb_we, i_wb_rd, i_wb_data  in  1/5/XLEN  writeback port, for the bypass.
REQ-012 i_flush  in  1  kill the current stage contents and the incoming instruction.
REQ-013 o_valid  out  1  pipeline register holds a valid instruction.
REQ-014 i_ready  in  1  downstream accepts this cycle.
REQ-015 o_instruction, o_pc, o_rs1_value, o_rs2_value, o_immediate  out  32/XLEN/XLEN/XLEN/XLEN  registered payload.
REQ-016 o_alu_op, o_alu_src, o_branch, o_jump, o_mem_write, o_mem_read, o_mem_to_reg, o_reg_write, o_illegal  out  2/1×8  registered controls.

Function
REQ-017 Accept event = i_valid && o_ready && !i_flush; on accept, all payload and control registers load on the next rising edge (latency 1 cycle); no negedge logic.
REQ-018 Hold: o_valid && !i_ready && !i_flush keeps every output stable.
REQ-019 o_valid next = accept ? 1 : (i_ready || i_flush) ? 0 : o_valid; i_flush has priority over a simultaneous accept.
REQ-020 Opcode decode; fields are alu_op/alu_src/branch/jump/mem_write/mem_read/mem_to_reg/reg_write:
 - R 0110011: 10/0/0/0/0/0/0/1
 - I-ALU 0010011: 10/1/0/0/0/0/0/1
 - LOAD 0000011: 00/1/0/0/0/1/1/1
 - STORE 0100011: 00/1/0/0/1/0/0/0
 - BRANCH 1100011: 01/0/1/0/0/0/0/0
 - JAL 1101111 and JALR 1100111: 00/1/0/1/0/0/0/1
 - LUI 0110111 and AUIPC 0010111: 00/1/0/0/0/0/0/1
REQ-021 Any other opcode, or instruction[1:0] != 11: o_illegal=1, all other controls 0, o_immediate=0.
REQ-022 Immediate is sign-extended to XLEN:
 - I: [31:20]
 - S: {[31:25],[11:7]}
 - B: {[31],[7],[30:25],[11:8],0}
 - U: {[31:12],12'b0}
 - J: {[31],[19:12],[20],[30:21],0}
REQ-023 Bypass (WB_BYPASS=1): if i_wb_we && i_wb_rd!=0 && i_wb_rd==rsN index, o_rsN_value captures i_wb_data instead of i_rsN_value.
REQ-024 Index 0 always yields operand value 0, regardless of the register file and the bypass.
REQ-025 Controls for non-writing opcodes are driven explicitly to 0; no field holds a stale value.

Reset
REQ-026 i_rst has priority over all other inputs and sets o_valid=0 and every payload/control output to 0 on the next edge.
REQ-027 o_ready reads 1 in the cycle after reset; reset during a held instruction discards it.

Structure
REQ-028 Shared package riscv_pkg holds the opcode constants, the imm-format enum (I,S,B,U,J,NONE) and a ctrl_t struct for the control bundle.
REQ-029 Immediate generation lives in a combinational sub-module imm_gen (inputs: instruction, format; output: XLEN immediate); everything else stays in decode_pipe_stage.

Verification
REQ-030 ld x5,8(x2): 0x00813283, i_valid=1, i_ready=1 -> next cycle o_valid=1, o_immediate=8, mem_read=1, mem_to_reg=1, reg_write=1, alu_src=1.
REQ-031 sd x5,-8(x2): 0xFE513C23 -> o_immediate=0xFFFF_FFFF_FFFF_FFF8, mem_write=1, reg_write=0.
REQ-032 beq x1,x2,-4: 0xFE208EE3 -> o_immediate=-4, branch=1, alu_op=01; then i_ready=0 for 3 cycles -> outputs stable and o_ready=0.
REQ-033 Bypass: rs1=2, i_rs1_value=0x11, i_wb_we=1, i_wb_rd=2, i_wb_data=0x99 -> o_rs1_value=0x99; same stimulus with i_wb_rd=0 -> 0x11.
REQ-034 Simultaneous i_flush and accept -> o_valid=0 next cycle; opcode 0x7F -> o_illegal=1 and all other controls 0.
REQ-035 i_rst asserted mid-stall -> all outputs 0 on the next edge, then o_ready=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode constants, immediate formats and
// the registered control bundle produced by the decode stage.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction; the result is sign-extended to XLEN and
// is zero for instructions that carry no immediate.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instruction,
  input  imm_fmt_e        format,
  output logic [XLEN-1:0] immediate
);

  logic [31:0] raw;
  logic        unused_opcode;

  assign unused_opcode = ^instruction[6:0];

  always_comb begin
    raw = '0;
    unique case (format)
      FMT_I:   raw = {{20{instruction[31]}}, instruction[31:20]};
      FMT_S:   raw = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B:   raw = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      FMT_U:   raw = {instruction[31:12], 12'b0};
      FMT_J:   raw = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  assign immediate = XLEN'($signed(raw));

endmodule

// File: rtl/decode_pipe_stage.sv
// RISC-V decode stage with a valid/ready pipeline register, operand fetch from
// the register file and an optional writeback-to-decode bypass.
module decode_pipe_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instruction,
  output logic [4:0]      o_rs1_index,
  output logic [4:0]      o_rs2_index,
  input  logic [XLEN-1:0] i_rs1_value,
  input  logic [XLEN-1:0] i_rs2_value,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [31:0]     o_instruction,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_rs1_value,
  output logic [XLEN-1:0] o_rs2_value,
  output logic [XLEN-1:0] o_immediate,
  output logic [1:0]      o_alu_op,
  output logic            o_alu_src,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_mem_write,
  output logic            o_mem_read,
  output logic            o_mem_to_reg,
  output logic            o_reg_write,
  output logic            o_illegal
);

  ctrl_t           dec_ctrl;
  imm_fmt_e        dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] rs1_sel;
  logic [XLEN-1:0] rs2_sel;
  logic            accept;
  ctrl_t           ctrl_q;

  assign o_rs1_index = i_instruction[19:15];
  assign o_rs2_index = i_instruction[24:20];
  assign o_ready     = !o_valid || i_ready;
  assign accept      = i_valid && o_ready && !i_flush;

  always_comb begin
    dec_ctrl = '0;
    dec_fmt  = FMT_NONE;
    if (i_instruction[1:0] != 2'b11) begin
      dec_ctrl.illegal = 1'b1;
    end else begin
      unique case (i_instruction[6:0])
        OP_R: begin
          dec_ctrl.alu_op    = ALU_FUNCT;
          dec_ctrl.reg_write = 1'b1;
        end
        OP_I_ALU: begin
          dec_ctrl.alu_op    = ALU_FUNCT;
          dec_ctrl.alu_src   = 1'b1;
          dec_ctrl.reg_write = 1'b1;
          dec_fmt            = FMT_I;
        end
        OP_LOAD: begin
          dec_ctrl.alu_src    = 1'b1;
          dec_ctrl.mem_read   = 1'b1;
          dec_ctrl.mem_to_reg = 1'b1;
          dec_ctrl.reg_write  = 1'b1;
          dec_fmt             = FMT_I;
        end
        OP_STORE: begin
          dec_ctrl.alu_src   = 1'b1;
          dec_ctrl.mem_write = 1'b1;
          dec_fmt            = FMT_S;
        end
        OP_BRANCH: begin
          dec_ctrl.alu_op = ALU_BRANCH;
          dec_ctrl.branch = 1'b1;
          dec_fmt         = FMT_B;
        end
        OP_JAL, OP_JALR: begin
          dec_ctrl.alu_src   = 1'b1;
          dec_ctrl.jump      = 1'b1;
          dec_ctrl.reg_write = 1'b1;
          dec_fmt            = (i_instruction[6:0] == OP_JAL) ? FMT_J : FMT_I;
        end
        OP_LUI, OP_AUIPC: begin
          dec_ctrl.alu_src   = 1'b1;
          dec_ctrl.reg_write = 1'b1;
          dec_fmt            = FMT_U;
        end
        default: dec_ctrl.illegal = 1'b1;
      endcase
    end
  end

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instruction(i_instruction),
    .format     (dec_fmt),
    .immediate  (dec_imm)
  );

  // x0 wins over both the register file and the bypass.
  always_comb begin
    rs1_sel = i_rs1_value;
    rs2_sel = i_rs2_value;
    if (WB_BYPASS && i_wb_we && (i_wb_rd != 5'd0)) begin
      if (i_wb_rd == o_rs1_index) rs1_sel = i_wb_data;
      if (i_wb_rd == o_rs2_index) rs2_sel = i_wb_data;
    end
    if (o_rs1_index == 5'd0) rs1_sel = '0;
    if (o_rs2_index == 5'd0) rs2_sel = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid       <= 1'b0;
      o_instruction <= '0;
      o_pc          <= '0;
      o_rs1_value   <= '0;
      o_rs2_value   <= '0;
      o_immediate   <= '0;
      ctrl_q        <= '0;
    end else if (accept) begin
      o_valid       <= 1'b1;
      o_instruction <= i_instruction;
      o_pc          <= i_pc;
      o_rs1_value   <= rs1_sel;
      o_rs2_value   <= rs2_sel;
      o_immediate   <= dec_imm;
      ctrl_q        <= dec_ctrl;
    end else if (i_ready || i_flush) begin
      o_valid <= 1'b0;
    end
  end

  assign o_alu_op     = ctrl_q.alu_op;
  assign o_alu_src    = ctrl_q.alu_src;
  assign o_branch     = ctrl_q.branch;
  assign o_jump       = ctrl_q.jump;
  assign o_mem_write  = ctrl_q.mem_write;
  assign o_mem_read   = ctrl_q.mem_read;
  assign o_mem_to_reg = ctrl_q.mem_to_reg;
  assign o_reg_write  = ctrl_q.reg_write;
  assign o_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Randomized and directed check of decode_pipe_stage against a behavioural
// model of the decode rules and the valid/ready register.
module tb_decode_pipe_stage;

  logic        clk = 1'b0;
  logic        rst, valid, ready, flush, wb_we;
  logic [63:0] pc, rs1_val, rs2_val, wb_data;
  logic [31:0] instr;
  logic [4:0]  wb_rd;

  logic        o_ready, o_valid;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] o_instr;
  logic [63:0] o_pc, o_rs1, o_rs2, o_imm;
  logic [1:0]  o_alu_op;
  logic        o_alu_src, o_branch, o_jump, o_mem_write, o_mem_read;
  logic        o_mem_to_reg, o_reg_write, o_illegal;

  decode_pipe_stage #(
    .XLEN     (64),
    .WB_BYPASS(1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .o_ready      (o_ready),
    .i_pc         (pc),
    .i_instruction(instr),
    .o_rs1_index  (rs1_idx),
    .o_rs2_index  (rs2_idx),
    .i_rs1_value  (rs1_val),
    .i_rs2_value  (rs2_val),
    .i_wb_we      (wb_we),
    .i_wb_rd      (wb_rd),
    .i_wb_data    (wb_data),
    .i_flush      (flush),
    .o_valid      (o_valid),
    .i_ready      (ready),
    .o_instruction(o_instr),
    .o_pc         (o_pc),
    .o_rs1_value  (o_rs1),
    .o_rs2_value  (o_rs2),
    .o_immediate  (o_imm),
    .o_alu_op     (o_alu_op),
    .o_alu_src    (o_alu_src),
    .o_branch     (o_branch),
    .o_jump       (o_jump),
    .o_mem_write  (o_mem_write),
    .o_mem_read   (o_mem_read),
    .o_mem_to_reg (o_mem_to_reg),
    .o_reg_write  (o_reg_write),
    .o_illegal    (o_illegal)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Expected register contents.
  logic        e_valid = 1'b0;
  logic [31:0] e_instr;
  logic [63:0] e_pc, e_rs1, e_rs2, e_imm;
  logic [9:0]  e_ctrl;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
    if (v[bits-1]) return v - (64'd1 << bits);
    return v;
  endfunction

  // Control vector {alu_op, alu_src, branch, jump, mem_write, mem_read, mem_to_reg, reg_write, illegal}
  // and immediate kind (0 none, 1 I, 2 S, 3 B, 4 U, 5 J) straight from the opcode table.
  function automatic void ref_decode(input logic [31:0] w, output logic [9:0] c, output logic [63:0] imm);
    int kind;
    logic [63:0] x;
    x = {32'd0, w};
    kind = 0;
    if (w[1:0] != 2'b11) c = 10'b00_0000000_1;
    else case (w[6:0])
      7'b0110011: c = 10'b10_0000001_0;
      7'b0010011: begin c = 10'b10_1000001_0; kind = 1; end
      7'b0000011: begin c = 10'b00_1000111_0; kind = 1; end
      7'b0100011: begin c = 10'b00_1001000_0; kind = 2; end
      7'b1100011: begin c = 10'b01_0100000_0; kind = 3; end
      7'b1101111: begin c = 10'b00_1010001_0; kind = 5; end
      7'b1100111: begin c = 10'b00_1010001_0; kind = 1; end
      7'b0110111, 7'b0010111: begin c = 10'b00_1000001_0; kind = 4; end
      default:    c = 10'b00_0000000_1;
    endcase
    case (kind)
      1: imm = sext(x >> 20, 12);
      2: imm = sext(((x >> 25) << 5) | ((x >> 7) & 31), 12);
      3: imm = sext((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) |
                    (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1), 13);
      4: imm = sext(x & 64'hFFFF_F000, 32);
      5: imm = sext((((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) |
                    (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1), 21);
      default: imm = 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_operand(input logic [4:0] idx, input logic [63:0] rf);
    if (idx == 0) return 64'd0;
    if (wb_we && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic cycle();
    logic acc;
    logic [9:0]  c;
    logic [63:0] imm;
    #1;
    if (!rst) check("ready", {63'd0, o_ready}, {63'd0, !e_valid || ready});
    check("rs1_index", {59'd0, rs1_idx}, {59'd0, instr[19:15]});
    check("rs2_index", {59'd0, rs2_idx}, {59'd0, instr[24:20]});
    if (rst) begin
      e_valid = 0; e_instr = 0; e_pc = 0; e_rs1 = 0; e_rs2 = 0; e_imm = 0; e_ctrl = 0;
    end else begin
      acc = valid && (!e_valid || ready) && !flush;
      if (acc) begin
        ref_decode(instr, c, imm);
        e_valid = 1; e_instr = instr; e_pc = pc; e_ctrl = c; e_imm = imm;
        e_rs1 = ref_operand(instr[19:15], rs1_val);
        e_rs2 = ref_operand(instr[24:20], rs2_val);
      end else if (ready || flush) e_valid = 0;
    end
    @(posedge clk);
    #1;
    check("valid", {63'd0, o_valid}, {63'd0, e_valid});
    check("instruction", {32'd0, o_instr}, {32'd0, e_instr});
    check("pc", o_pc, e_pc);
    check("rs1_value", o_rs1, e_rs1);
    check("rs2_value", o_rs2, e_rs2);
    check("immediate", o_imm, e_imm);
    check("ctrl", {54'd0, o_alu_op, o_alu_src, o_branch, o_jump, o_mem_write, o_mem_read,
                   o_mem_to_reg, o_reg_write, o_illegal}, {54'd0, e_ctrl});
  endtask

  task automatic drive(input logic [31:0] w, input logic v, input logic r, input logic f);
    instr = w; valid = v; ready = r; flush = f;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001011};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 15) == 0) w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  initial begin
    rst = 1; valid = 0; ready = 1; flush = 0; wb_we = 0; wb_rd = 0;
    pc = 0; rs1_val = 0; rs2_val = 0; wb_data = 0; instr = 0;
    cycle();
    rst = 0;

    // ld x5,8(x2)
    pc = 64'h1000; rs1_val = 64'h55; rs2_val = 64'h66;
    drive(32'h0081_3283, 1, 1, 0);
    cycle();
    check("ld_imm", o_imm, 64'd8);
    check("ld_ctrl", {60'd0, o_mem_read, o_mem_to_reg, o_reg_write, o_alu_src}, 64'hF);

    // sd x5,-8(x2)
    drive(32'hFE51_3C23, 1, 1, 0);
    cycle();
    check("sd_imm", o_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check("sd_ctrl", {62'd0, o_mem_write, o_reg_write}, 64'd2);

    // beq x1,x2,-4 then a three-cycle stall
    drive(32'hFE20_8EE3, 1, 1, 0);
    cycle();
    check("beq_imm", o_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq_op", {61'd0, o_alu_op, o_branch}, 64'b011);
    drive(32'h0081_3283, 1, 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      cycle();
      check("stall_imm", o_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      check("stall_ready", {63'd0, o_ready}, 64'd0);
    end

    // Bypass on rs1=x2 (addi x3,x2,0), then with wb_rd=0
    drive(32'h0001_0193, 1, 1, 0);
    rs1_val = 64'h11; wb_we = 1; wb_rd = 2; wb_data = 64'h99;
    cycle();
    check("bypass_hit", o_rs1, 64'h99);
    wb_rd = 0;
    cycle();
    check("bypass_x0", o_rs1, 64'h11);
    wb_we = 0;

    // Flush beats accept; then an illegal opcode
    drive(32'h0000_0033, 1, 1, 1);
    cycle();
    check("flush_valid", {63'd0, o_valid}, 64'd0);
    drive(32'h0000_007F, 1, 1, 0);
    cycle();
    check("illegal", {54'd0, o_alu_op, o_alu_src, o_branch, o_jump, o_mem_write, o_mem_read,
                      o_mem_to_reg, o_reg_write, o_illegal}, 64'd1);

    // Reset in the middle of a stall
    drive(32'h0000_0033, 1, 0, 0);
    cycle();
    rst = 1;
    cycle();
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    rst = 0; valid = 0;
    #1 check("rst_ready", {63'd0, o_ready}, 64'd1);
    cycle();

    // Randomized traffic
    for (int unsigned n = 0; n < 600; n++) begin
      instr   = rand_instr();
      valid   = ($urandom_range(0, 3) != 0);
      ready   = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      pc      = {$urandom, $urandom};
      rs1_val = {$urandom, $urandom};
      rs2_val = {$urandom, $urandom};
      wb_data = {$urandom, $urandom};
      wb_we   = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: wb_rd = instr[19:15];
        1: wb_rd = instr[24:20];
        2: wb_rd = 5'd0;
        default: wb_rd = 5'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) instr[19:15] = 5'd0;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
